ddr3_mcb_req_gen: RTL
=====================

Name: ddr3_mcb_req_gen

Overview:
- Request initiator that sits between the AXI-side front end and the DDR3 MCB top.
- Accepts linear read/write commands, splits each address into bank/row/column, and tracks the open row per bank to classify the command as row_hit, row_miss or row_empty.
- Issues the command to the MCB, supplies write data on ddr3_mcb_wdat_req, and returns read data captured on ddr3_mcb_rdat_vld.

Parameters:
- MCB_B_W, 3: bank address width; the table holds 2^MCB_B_W banks.
- MCB_R_W, 14: row address width.
- MCB_C_W, 10: column address width.
- MCB_D_W, 128: MCB data word width.
- MCB_BE_W, 16: write byte-enable width (MCB_D_W/8).

Ports:
- ddr3_mcb_clk  in  1  single clock.
- ddr3_mcb_rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  user command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_wr_n  in  1  0=write, 1=read.
- cmd_bl  in  2  burst code, forwarded unchanged.
- cmd_addr  in  MCB_R_W+MCB_B_W+MCB_C_W  linear address, {row,bank,col}.
- cmd_wdat  in  MCB_D_W  write data, sampled with the command.
- cmd_wbe  in  MCB_BE_W  byte enables, sampled with the command.
- rsp_valid  out  1  read data valid, 1-cycle pulse.
- rsp_rdat  out  MCB_D_W  read data.
- ddr3_mcb_i_ready  in  1  MCB initialisation complete.
- ddr3_mcb_busy  in  1  MCB executing a command.
- ddr3_mcb_prea  in  1  MCB precharge-all/refresh pulse; all banks closed.
- row_hit, row_miss, row_empty  out  1 each  one-hot classification, 1-cycle pulse.
- ddr3_mcb_wr_n  out  1.
- ddr3_mcb_bl  out  2.
- ddr3_mcb_ba  out  MCB_B_W.
- ddr3_mcb_ra  out  MCB_R_W.
- ddr3_mcb_ca  out  MCB_C_W.
- ddr3_mcb_wdat_req  in  1  MCB requests write data.
- ddr3_mcb_wdat  out  MCB_D_W.
- ddr3_mcb_wbe  out  MCB_BE_W.
- ddr3_mcb_rdat_vld  in  1.
- ddr3_mcb_rdat  in  MCB_D_W.

Behaviour:
- Reset values:
  - All outputs 0, except ddr3_mcb_wr_n=1.
  - All bank-table valid bits cleared.
  - FSM enters INIT.
- FSM states:
  - INIT: cmd_ready=0. Move to IDLE when ddr3_mcb_i_ready=1.
  - IDLE: cmd_ready=1. On acceptance, register wr_n, bl, ba/ra/ca, wdat and wbe, then go to CLASSIFY.
  - CLASSIFY: cmd_ready=0. Look up the table for ba.
    - valid=0 gives empty.
    - valid=1 and row==ra gives hit.
    - Otherwise gives miss.
    - Go to ISSUE.
  - ISSUE: waits while ddr3_mcb_busy=1 or ddr3_mcb_prea=1. When neither is high, pulse exactly one of row_hit/row_miss/row_empty for 1 cycle, with addr/wr_n/bl valid in that same cycle.
    - Table update in the same cycle: miss or empty writes valid=1, row=ra; hit leaves the entry unchanged.
    - Go to WAIT_BUSY.
  - WAIT_BUSY: waits for ddr3_mcb_busy=1, then goes to WAIT_DATA.
  - WAIT_DATA:
    - Write: on ddr3_mcb_wdat_req, drive ddr3_mcb_wdat/wbe from the registers. These are held stable from ISSUE until the transaction completes.
    - Read: on ddr3_mcb_rdat_vld, capture ddr3_mcb_rdat. rsp_valid pulses the next cycle with rsp_rdat; rsp_rdat holds until the next read.
    - Then go to WAIT_DONE.
  - WAIT_DONE: waits for ddr3_mcb_busy=0, then returns to IDLE. This gives one command outstanding at a time.
- Prea versus classification: ddr3_mcb_prea clears all valid bits. If prea is asserted while in ISSUE, the pulse is suppressed and the FSM returns to CLASSIFY, so the stale classification is recomputed.
- Prea versus issue update: if prea and an issue update fall in the same cycle (cannot occur given the rule above), clear takes priority.
- Latency: best case from cmd acceptance to classification pulse is 2 cycles (CLASSIFY, then ISSUE with busy=0).
- Read data arriving early: ddr3_mcb_rdat_vld in WAIT_BUSY is also accepted, and the FSM skips to WAIT_DONE.
- Unexpected strobes: wdat_req or rdat_vld outside WAIT_BUSY/WAIT_DATA is ignored.
- ddr3_mcb_i_ready falling to 0: the FSM returns to INIT from any state, the bank table is cleared, and any in-flight command is dropped with no rsp_valid.
- Reset mid-operation: identical to the i_ready-fall case, and all outputs return to their reset values.

Optional Feature:
- Macro DDR3_MCB_REQ_STAT_EN.
- Defined: adds three 32-bit counters, stat_hit_cnt, stat_miss_cnt and stat_empty_cnt (outputs). Each increments on its classification pulse, saturates at 0xFFFFFFFF, and is cleared by reset.
- Undefined: no counters and no stat ports.

Decomposition:
- Shared package ddr3_mcb_req_pkg holds:
  - FSM state encodings (INIT, IDLE, CLASSIFY, ISSUE, WAIT_BUSY, WAIT_DATA, WAIT_DONE).
  - Classification codes.
  - Address field offset constants derived from MCB_C_W/MCB_B_W.
- Sub-module ddr3_mcb_bank_tbl: per-bank valid and row registers, combinational lookup (hit/miss/empty), write port, and clear-all.

Test Plan:
- Init gating: i_ready=0 for 20 cycles with cmd_valid=1 -> cmd_ready stays 0. i_ready=1 -> cmd_ready=1 the next cycle.
- Row empty then hit: read addr row=0x12, bank=3, col=0x40 -> row_empty pulse with ba=3, ra=0x12, ca=0x40. Second read, same row, col=0x48 -> row_hit.
- Row miss: after the above, write row=0x13, bank=3 -> row_miss. Wdat 0xA5.. driven when wdat_req=1. Table entry for bank 3 becomes row=0x13.
- Read return: rdat_vld with rdat=0xDEADBEEF.. -> rsp_valid 1 cycle later with the same data, exactly one pulse.
- Refresh interaction: prea pulse, then a read to bank 3 row 0x13 -> row_empty, not row_hit. Prea asserted during ISSUE -> no classification pulse that cycle, reclassified as row_empty.
- Reset and i_ready fall mid-write: assert ddr3_mcb_rst in WAIT_DATA -> all outputs 0, wr_n=1, FSM in INIT, next command classified row_empty. Dropping i_ready in WAIT_DATA gives the same outcome.

Source files
------------

// File: rtl/ddr3_mcb_req_pkg.sv
// Shared types and address-field helpers for the DDR3 MCB request generator.
package ddr3_mcb_req_pkg;

    typedef enum logic [2:0] {
        ST_INIT      = 3'd0,
        ST_IDLE      = 3'd1,
        ST_CLASSIFY  = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_BUSY = 3'd4,
        ST_WAIT_DATA = 3'd5,
        ST_WAIT_DONE = 3'd6
    } req_state_e;

    typedef enum logic [1:0] {
        CLS_EMPTY = 2'd0,
        CLS_HIT   = 2'd1,
        CLS_MISS  = 2'd2
    } row_cls_e;

    // Linear address layout is {row, bank, col}, column in the LSBs.
    localparam int unsigned CA_LSB = 0;

    function automatic int unsigned ba_lsb(input int unsigned c_w);
        return c_w;
    endfunction

    function automatic int unsigned ra_lsb(input int unsigned c_w, input int unsigned b_w);
        return c_w + b_w;
    endfunction

endpackage

// File: rtl/ddr3_mcb_bank_tbl.sv
// Per-bank open-row table: valid/row registers, combinational hit/miss/empty lookup,
// single write port and clear-all.
module ddr3_mcb_bank_tbl
    import ddr3_mcb_req_pkg::*;
#(
    parameter int unsigned MCB_B_W = 3,
    parameter int unsigned MCB_R_W = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               wr_en,
    input  logic [MCB_B_W-1:0] wr_ba,
    input  logic [MCB_R_W-1:0] wr_ra,
    input  logic [MCB_B_W-1:0] rd_ba,
    input  logic [MCB_R_W-1:0] rd_ra,
    output row_cls_e           rd_cls
);

    localparam int unsigned N_BANK = 2 ** MCB_B_W;

    logic [N_BANK-1:0]  vld;
    logic [MCB_R_W-1:0] row [N_BANK];

    // Clear wins over a same-cycle write so a precharge never leaves a stale open row.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld <= '0;
        end else if (wr_en) begin
            vld[wr_ba] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            row[wr_ba] <= wr_ra;
        end
    end

    always_comb begin
        rd_cls = CLS_EMPTY;
        if (vld[rd_ba]) begin
            rd_cls = (row[rd_ba] == rd_ra) ? CLS_HIT : CLS_MISS;
        end
    end

endmodule

// File: rtl/ddr3_mcb_req_gen.sv
// DDR3 MCB request initiator: accepts one user command at a time, classifies it against
// the open-row table and drives the MCB. Optional counters under DDR3_MCB_REQ_STAT_EN.
module ddr3_mcb_req_gen
    import ddr3_mcb_req_pkg::*;
#(
    parameter int unsigned MCB_B_W  = 3,
    parameter int unsigned MCB_R_W  = 14,
    parameter int unsigned MCB_C_W  = 10,
    parameter int unsigned MCB_D_W  = 128,
    parameter int unsigned MCB_BE_W = 16
) (
    input  logic                               ddr3_mcb_clk,
    input  logic                               ddr3_mcb_rst,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic                               cmd_wr_n,
    input  logic [1:0]                         cmd_bl,
    input  logic [MCB_R_W+MCB_B_W+MCB_C_W-1:0] cmd_addr,
    input  logic [MCB_D_W-1:0]                 cmd_wdat,
    input  logic [MCB_BE_W-1:0]                cmd_wbe,
    output logic                               rsp_valid,
    output logic [MCB_D_W-1:0]                 rsp_rdat,
    input  logic                               ddr3_mcb_i_ready,
    input  logic                               ddr3_mcb_busy,
    input  logic                               ddr3_mcb_prea,
    output logic                               row_hit,
    output logic                               row_miss,
    output logic                               row_empty,
    output logic                               ddr3_mcb_wr_n,
    output logic [1:0]                         ddr3_mcb_bl,
    output logic [MCB_B_W-1:0]                 ddr3_mcb_ba,
    output logic [MCB_R_W-1:0]                 ddr3_mcb_ra,
    output logic [MCB_C_W-1:0]                 ddr3_mcb_ca,
    input  logic                               ddr3_mcb_wdat_req,
    output logic [MCB_D_W-1:0]                 ddr3_mcb_wdat,
    output logic [MCB_BE_W-1:0]                ddr3_mcb_wbe,
    input  logic                               ddr3_mcb_rdat_vld,
    input  logic [MCB_D_W-1:0]                 ddr3_mcb_rdat
`ifdef DDR3_MCB_REQ_STAT_EN
    ,
    output logic [31:0]                        stat_hit_cnt,
    output logic [31:0]                        stat_miss_cnt,
    output logic [31:0]                        stat_empty_cnt
`endif
);

    localparam int unsigned BA_LSB = ba_lsb(MCB_C_W);
    localparam int unsigned RA_LSB = ra_lsb(MCB_C_W, MCB_B_W);

    req_state_e            state;
    logic                  wr_n_q;
    logic [1:0]            bl_q;
    logic [MCB_B_W-1:0]    ba_q;
    logic [MCB_R_W-1:0]    ra_q;
    logic [MCB_C_W-1:0]    ca_q;
    logic [MCB_D_W-1:0]    wdat_q;
    logic [MCB_BE_W-1:0]   wbe_q;
    row_cls_e              cls_q;
    row_cls_e              tbl_cls;
    logic                  issue_fire;
    logic                  tbl_clr;
    logic                  tbl_wr;

    assign issue_fire = (state == ST_ISSUE) && ddr3_mcb_i_ready && !ddr3_mcb_prea && !ddr3_mcb_busy;
    assign tbl_clr    = ddr3_mcb_prea || !ddr3_mcb_i_ready;
    assign tbl_wr     = issue_fire && (cls_q != CLS_HIT);

    ddr3_mcb_bank_tbl #(
        .MCB_B_W (MCB_B_W),
        .MCB_R_W (MCB_R_W)
    ) u_bank_tbl (
        .clk    (ddr3_mcb_clk),
        .rst    (ddr3_mcb_rst),
        .clr    (tbl_clr),
        .wr_en  (tbl_wr),
        .wr_ba  (ba_q),
        .wr_ra  (ra_q),
        .rd_ba  (ba_q),
        .rd_ra  (ra_q),
        .rd_cls (tbl_cls)
    );

    // Losing MCB init behaves exactly like reset: in-flight command dropped, outputs cleared.
    always_ff @(posedge ddr3_mcb_clk) begin
        row_hit   <= 1'b0;
        row_miss  <= 1'b0;
        row_empty <= 1'b0;
        rsp_valid <= 1'b0;
        if (ddr3_mcb_rst || !ddr3_mcb_i_ready) begin
            state         <= ST_INIT;
            cmd_ready     <= 1'b0;
            rsp_rdat      <= '0;
            ddr3_mcb_wr_n <= 1'b1;
            ddr3_mcb_bl   <= '0;
            ddr3_mcb_ba   <= '0;
            ddr3_mcb_ra   <= '0;
            ddr3_mcb_ca   <= '0;
            ddr3_mcb_wdat <= '0;
            ddr3_mcb_wbe  <= '0;
            wr_n_q        <= 1'b1;
            bl_q          <= '0;
            ba_q          <= '0;
            ra_q          <= '0;
            ca_q          <= '0;
            wdat_q        <= '0;
            wbe_q         <= '0;
            cls_q         <= CLS_EMPTY;
        end else begin
            case (state)
                ST_INIT: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                ST_IDLE: begin
                    if (cmd_valid) begin
                        wr_n_q    <= cmd_wr_n;
                        bl_q      <= cmd_bl;
                        ca_q      <= cmd_addr[CA_LSB +: MCB_C_W];
                        ba_q      <= cmd_addr[BA_LSB +: MCB_B_W];
                        ra_q      <= cmd_addr[RA_LSB +: MCB_R_W];
                        wdat_q    <= cmd_wdat;
                        wbe_q     <= cmd_wbe;
                        cmd_ready <= 1'b0;
                        state     <= ST_CLASSIFY;
                    end
                end
                ST_CLASSIFY: begin
                    // A precharge here would make the lookup stale; look again next cycle.
                    if (!ddr3_mcb_prea) begin
                        cls_q <= tbl_cls;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ddr3_mcb_prea) begin
                        state <= ST_CLASSIFY;
                    end else if (!ddr3_mcb_busy) begin
                        row_hit       <= (cls_q == CLS_HIT);
                        row_miss      <= (cls_q == CLS_MISS);
                        row_empty     <= (cls_q == CLS_EMPTY);
                        ddr3_mcb_wr_n <= wr_n_q;
                        ddr3_mcb_bl   <= bl_q;
                        ddr3_mcb_ba   <= ba_q;
                        ddr3_mcb_ra   <= ra_q;
                        ddr3_mcb_ca   <= ca_q;
                        if (!wr_n_q) begin
                            ddr3_mcb_wdat <= wdat_q;
                            ddr3_mcb_wbe  <= wbe_q;
                        end
                        state <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (wr_n_q && ddr3_mcb_rdat_vld) begin
                        rsp_valid <= 1'b1;
                        rsp_rdat  <= ddr3_mcb_rdat;
                        state     <= ST_WAIT_DONE;
                    end else if (!wr_n_q && ddr3_mcb_wdat_req) begin
                        state <= ST_WAIT_DONE;
                    end else if (ddr3_mcb_busy) begin
                        state <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (wr_n_q && ddr3_mcb_rdat_vld) begin
                        rsp_valid <= 1'b1;
                        rsp_rdat  <= ddr3_mcb_rdat;
                        state     <= ST_WAIT_DONE;
                    end else if (!wr_n_q && ddr3_mcb_wdat_req) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!ddr3_mcb_busy) begin
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    cmd_ready <= 1'b0;
                    state     <= ST_INIT;
                end
            endcase
        end
    end

`ifdef DDR3_MCB_REQ_STAT_EN
    // Saturating classification counters, cleared only by reset.
    always_ff @(posedge ddr3_mcb_clk) begin
        if (ddr3_mcb_rst) begin
            stat_hit_cnt   <= '0;
            stat_miss_cnt  <= '0;
            stat_empty_cnt <= '0;
        end else if (issue_fire) begin
            case (cls_q)
                CLS_HIT: begin
                    if (stat_hit_cnt != 32'hFFFF_FFFF) stat_hit_cnt <= stat_hit_cnt + 32'd1;
                end
                CLS_MISS: begin
                    if (stat_miss_cnt != 32'hFFFF_FFFF) stat_miss_cnt <= stat_miss_cnt + 32'd1;
                end
                default: begin
                    if (stat_empty_cnt != 32'hFFFF_FFFF) stat_empty_cnt <= stat_empty_cnt + 32'd1;
                end
            endcase
        end
    end
`endif

endmodule
